// File: rtl/serial_bus_deser_if.sv
// Bus bundle for serial_bus_deser.
//   in, in_vld, sof : serial bit, bit-valid strobe and start-of-frame marker
//   clr             : synchronous clear of the sticky flags
//   out, out_vld    : assembled word and its valid flag
//   out_rdy         : consumer accepts out while out_vld is high
//   overflow        : sticky, a completed word was dropped
//   frame_err       : sticky, a frame was aborted by an early sof
// master: the side that drives serial bits and consumes words. slave: the deserializer.
interface serial_bus_deser_if #(
  parameter int unsigned WIDTH = 2
);
  logic             in;
  logic             in_vld;
  logic             sof;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_vld;
  logic             out_rdy;
  logic             overflow;
  logic             frame_err;

  modport master (
    output in, in_vld, sof, clr, out_rdy,
    input  out, out_vld, overflow, frame_err
  );

  modport slave (
    input  in, in_vld, sof, clr, out_rdy,
    output out, out_vld, overflow, frame_err
  );
endinterface

// File: rtl/serial_bus_deser.sv
// Serial-to-parallel receiver. Collects WIDTH bits per frame, opened by sof, into a shifter.
// A completed word goes to a one-word holding register, which is read through a valid/ready
// handshake. Sticky flags report dropped words (overflow) and frames restarted by an early sof
// (frame_err).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial input, parallel output and flags (see serial_bus_deser_if)
// MSB_FIRST = 0 puts received bit k in out[k]. MSB_FIRST = 1 puts it in out[WIDTH-1-k].
module serial_bus_deser #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_bus_deser_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic             word_done;
  logic [WIDTH-1:0] word_new;
  logic             ferr_set;
  logic             ovf_set;

  // Write bit b into w at the position that received bit k maps to.
  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] w,
                                             input logic [CntW-1:0]  k,
                                             input logic             b);
    int unsigned idx;
    logic [WIDTH-1:0] r;
    idx = (MSB_FIRST != 0) ? (WIDTH - 1 - 32'(k)) : 32'(k);
    r = w;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == idx) r[i] = b;
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state: frame assembly, holding register and sticky flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    word_new  = '0;
    ferr_set  = 1'b0;
    ovf_set   = 1'b0;
    out_d     = out_q;
    out_vld_d = out_vld_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_vld && bus.sof) begin
          shift_d = place('0, '0, bus.in);
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.in_vld) begin
          if (bus.sof) begin
            // Early sof drops the partial word, and this bit starts a new frame.
            ferr_set = 1'b1;
            shift_d  = place('0, '0, bus.in);
            cnt_d    = CntW'(1);
          end else if (cnt_q == LastCnt) begin
            word_new  = place(shift_q, cnt_q, bus.in);
            word_done = 1'b1;
            shift_d   = '0;
            cnt_d     = '0;
            state_d   = StIdle;
          end else begin
            shift_d = place(shift_q, cnt_q, bus.in);
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The holding register accepts a new word when it is empty or is drained in this cycle.
    if (word_done) begin
      if (!out_vld_q || bus.out_rdy) begin
        out_d     = word_new;
        out_vld_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (out_vld_q && bus.out_rdy) begin
      out_vld_d = 1'b0;
    end

    // A set event in the same cycle wins over clr.
    ovf_d  = ovf_set  ? 1'b1 : (bus.clr ? 1'b0 : ovf_q);
    ferr_d = ferr_set ? 1'b1 : (bus.clr ? 1'b0 : ferr_q);
  end

  // Outputs are driven only from flops, so there is no path from out_rdy to them.
  always_comb begin
    bus.out       = out_q;
    bus.out_vld   = out_vld_q;
    bus.overflow  = ovf_q;
    bus.frame_err = ferr_q;
  end

endmodule

// File: doc/serial_bus_deser.md
# serial_bus_deser

Receive-side deserializer for the single-bit serial link driven from a parallel bus. It accepts one serial bit per enabled cycle, assembles WIDTH-bit words framed by a start-of-frame strobe, and presents each word on a parallel output with a valid/ready handshake. A one-word holding register decouples the shifter from the consumer, and sticky flags report dropped words and broken frames.

## Interface
- WIDTH, 2, word width in bits (≥2)
- MSB_FIRST, 0, 0 = first received bit lands in out[0]; 1 = first received bit lands in out[WIDTH-1]

- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  1  serial data bit
- in_vld  input  1  in is valid this cycle
- sof  input  1  start of frame; meaningful only with in_vld=1; marks in as bit 0 of a new word
- clr  input  1  synchronous clear of sticky flags
- out  output  WIDTH  assembled word
- out_vld  output  1  out holds an undelivered word
- out_rdy  input  1  consumer accepts out when out_vld=1
- overflow  output  1  sticky: a completed word was dropped
- frame_err  output  1  sticky: frame aborted by early sof

## Operation
- Reset (async assert, sync release): state IDLE, bit counter 0, shifter 0, out=0, out_vld=0, overflow=0, frame_err=0.
- States: IDLE (no frame open), SHIFT (frame open, count bits received).
- IDLE: in_vld=0 or sof=0 → stay; bits without sof are ignored. in_vld=1 & sof=1 → store bit 0, count=1, go SHIFT.
- SHIFT: in_vld=0 → hold. in_vld=1 & sof=0 → store bit at position count, count+1. in_vld=1 & sof=1 → discard partial word, set frame_err, restart with this bit as bit 0 (count=1, stay SHIFT).
- Completion: the cycle bit WIDTH-1 is accepted, the full word (shifter contents plus current bit) is offered to the holding register; state → IDLE, count → 0.
- Bit placement: MSB_FIRST=0 → bit k to out[k]; MSB_FIRST=1 → bit k to out[WIDTH-1-k].
- Holding register: loads completed word if out_vld=0, or if out_vld=1 & out_rdy=1 in the same cycle (drain and refill, out_vld stays 1). Otherwise word dropped, overflow set, held word unchanged.
- Handshake: transfer when out_vld & out_rdy; then out_vld clears unless refilled the same cycle. out stable while out_vld=1 & out_rdy=0. out keeps last value after drain.
- clr=1: overflow and frame_err → 0 next edge; a set event in the same cycle wins (flag stays 1).
- Counter width: clog2(WIDTH) bits; never exceeds WIDTH-1.

## Timing
- Latency: out_vld rises on the edge after the last bit is accepted (1 cycle).
- Throughput: one word per WIDTH valid cycles, back-to-back frames allowed (sof in the cycle after completion).
- out_rdy has no combinational path to out_vld or out inside the block.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately; partial and held words are lost.

## Test plan
- WIDTH=2, MSB_FIRST=0, out_rdy=1: cycle0 in_vld=1,sof=1,in=1; cycle1 in_vld=1,in=0 → cycle2 out=2'b01, out_vld=1 for one cycle.
- Same stimulus, MSB_FIRST=1 → out=2'b10; in_vld gaps of 3 cycles between the bits → same word, out_vld delayed accordingly.
- out_rdy=0, send words 2'b11 then 2'b01 → out stays 2'b11, overflow=1 after second word; raise out_rdy → one transfer of 2'b11, out_vld=0; clr → overflow=0.
- Full holding register with out_rdy=1 in the completion cycle of 2'b10 → out changes to 2'b10, out_vld stays 1, overflow=0.
- sof, in=1, then sof again with in=0, then in=1 → frame_err=1, out=2'b10 (MSB_FIRST=0); bits sent with sof=0 in IDLE → no out_vld.
- Assert rst_n=0 after first bit of a frame and while out_vld=1 → out=0, out_vld=0, flags 0 asynchronously; next clean frame delivers correctly.
